// File: rtl/tlb_maint_seq.sv
// TLB maintenance sequencer: steps EX maintenance ops onto the shared TLB ports,
// arbitrates search port 1 against dcache, and expands INVTLB into a per-entry walk.
module tlb_maint_seq #(
  parameter int TLBNUM = 32,
  parameter int IDX_W  = $clog2(TLBNUM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [2:0]       op_type,
  input  logic [4:0]       inv_op,
  input  logic [9:0]       inv_asid,
  input  logic [18:0]      inv_vpn,
  input  logic             flush,
  output logic             op_ready,
  input  logic             data_req_valid,
  output logic             data_grant,
  output logic             tlbsrch_en,
  input  logic             s1_found,
  input  logic [IDX_W-1:0] s1_index,
  output logic             tlbrd_en,
  output logic             tlbwr_en,
  output logic             tlbfill_en,
  output logic [IDX_W-1:0] rand_index,
  output logic             inv_en,
  output logic [IDX_W-1:0] inv_index,
  output logic [4:0]       inv_op_o,
  output logic [9:0]       inv_asid_o,
  output logic [18:0]      inv_vpn_o,
  output logic             done,
  output logic             srch_found,
  output logic [IDX_W-1:0] srch_index,
  output logic             inv_illegal,
  output logic             busy
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_INV_WALK, S_DONE} state_e;
  typedef enum logic [2:0] {
    OP_SRCH = 3'd0, OP_RD = 3'd1, OP_WR = 3'd2, OP_FILL = 3'd3, OP_INV = 3'd4
  } op_e;

  state_e           state_q, state_d;
  op_e              type_q, type_d;
  logic [4:0]       inv_op_q, inv_op_d;
  logic [9:0]       inv_asid_q, inv_asid_d;
  logic [18:0]      inv_vpn_q, inv_vpn_d;
  logic [IDX_W-1:0] rand_q, rand_d;
  logic [IDX_W-1:0] inv_idx_q, inv_idx_d;
  logic             srch_found_q, srch_found_d;
  logic [IDX_W-1:0] srch_index_q, srch_index_d;
  logic             inv_illegal_q, inv_illegal_d;
  logic             tlbsrch_en_q, tlbsrch_en_d;
  logic             tlbrd_en_q, tlbrd_en_d;
  logic             tlbwr_en_q, tlbwr_en_d;
  logic             tlbfill_en_q, tlbfill_en_d;
  logic             inv_en_q, inv_en_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             grant_ok_q, grant_ok_d;
  logic             accept;

  always_comb begin
    accept        = (state_q == S_IDLE) && !flush && op_valid;
    state_d       = state_q;
    type_d        = type_q;
    inv_op_d      = inv_op_q;
    inv_asid_d    = inv_asid_q;
    inv_vpn_d     = inv_vpn_q;
    inv_idx_d     = inv_idx_q;
    srch_found_d  = srch_found_q;
    srch_index_d  = srch_index_q;
    inv_illegal_d = inv_illegal_q;
    // Fill index only advances while no op is in flight, so FILL writes a stable slot.
    rand_d        = (state_q == S_IDLE && !accept) ? rand_q + IDX_W'(1) : rand_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          type_d        = op_e'(op_type);
          inv_op_d      = inv_op;
          inv_asid_d    = inv_asid;
          inv_vpn_d     = inv_vpn;
          srch_found_d  = 1'b0;
          srch_index_d  = '0;
          inv_illegal_d = 1'b0;
          state_d = (op_e'(op_type) == OP_INV && inv_op <= 5'd6) ? S_INV_WALK : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (type_q == OP_SRCH || type_q == OP_RD) begin
          state_d = S_WAIT;
        end else begin
          state_d       = S_DONE;
          inv_illegal_d = (type_q == OP_INV);
        end
      end
      S_WAIT: begin
        if (type_q == OP_SRCH) begin
          srch_found_d = s1_found;
          srch_index_d = s1_index;
        end
        state_d = S_DONE;
      end
      S_INV_WALK: begin
        inv_idx_d = inv_idx_q + IDX_W'(1);
        if (inv_idx_q == IDX_W'(TLBNUM - 1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobes are decoded from the next state so they register in step with it.
    tlbsrch_en_d = (state_d == S_ISSUE) && (type_d == OP_SRCH);
    tlbrd_en_d   = (state_d == S_ISSUE) && (type_d == OP_RD);
    tlbwr_en_d   = (state_d == S_ISSUE) && (type_d == OP_WR);
    tlbfill_en_d = (state_d == S_ISSUE) && (type_d == OP_FILL);
    inv_en_d     = (state_d == S_INV_WALK);
    done_d       = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);
    grant_ok_d   = (state_d == S_IDLE) || (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      type_q        <= OP_SRCH;
      inv_op_q      <= '0;
      inv_asid_q    <= '0;
      inv_vpn_q     <= '0;
      rand_q        <= '0;
      inv_idx_q     <= '0;
      srch_found_q  <= 1'b0;
      srch_index_q  <= '0;
      inv_illegal_q <= 1'b0;
      tlbsrch_en_q  <= 1'b0;
      tlbrd_en_q    <= 1'b0;
      tlbwr_en_q    <= 1'b0;
      tlbfill_en_q  <= 1'b0;
      inv_en_q      <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      grant_ok_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      type_q        <= type_d;
      inv_op_q      <= inv_op_d;
      inv_asid_q    <= inv_asid_d;
      inv_vpn_q     <= inv_vpn_d;
      rand_q        <= rand_d;
      inv_idx_q     <= inv_idx_d;
      srch_found_q  <= srch_found_d;
      srch_index_q  <= srch_index_d;
      inv_illegal_q <= inv_illegal_d;
      tlbsrch_en_q  <= tlbsrch_en_d;
      tlbrd_en_q    <= tlbrd_en_d;
      tlbwr_en_q    <= tlbwr_en_d;
      tlbfill_en_q  <= tlbfill_en_d;
      inv_en_q      <= inv_en_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      grant_ok_q    <= grant_ok_d;
    end
  end

  assign op_ready    = (state_q == S_IDLE) && !flush;
  assign data_grant  = data_req_valid && grant_ok_q;
  assign tlbsrch_en  = tlbsrch_en_q;
  assign tlbrd_en    = tlbrd_en_q;
  assign tlbwr_en    = tlbwr_en_q;
  assign tlbfill_en  = tlbfill_en_q;
  assign rand_index  = rand_q;
  assign inv_en      = inv_en_q;
  assign inv_index   = inv_idx_q;
  assign inv_op_o    = inv_op_q;
  assign inv_asid_o  = inv_asid_q;
  assign inv_vpn_o   = inv_vpn_q;
  assign done        = done_q;
  assign srch_found  = srch_found_q;
  assign srch_index  = srch_index_q;
  assign inv_illegal = inv_illegal_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_tlb_maint_seq.sv
// Bench for tlb_maint_seq: table of single ops, hand-written corner sequences and random
// traffic, all checked every cycle against a per-op timeline model.
module tb_tlb_maint_seq;
  localparam int TLBNUM = 32;
  localparam int IDX_W  = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             op_valid, flush, data_req_valid, s1_found;
  logic [2:0]       op_type;
  logic [4:0]       inv_op;
  logic [9:0]       inv_asid;
  logic [18:0]      inv_vpn;
  logic [IDX_W-1:0] s1_index;
  logic             op_ready, data_grant, tlbsrch_en, tlbrd_en, tlbwr_en, tlbfill_en;
  logic [IDX_W-1:0] rand_index, inv_index, srch_index;
  logic             inv_en, done, srch_found, inv_illegal, busy;
  logic [4:0]       inv_op_o;
  logic [9:0]       inv_asid_o;
  logic [18:0]      inv_vpn_o;

  always #5 clk = ~clk;

  tlb_maint_seq #(.TLBNUM(TLBNUM), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_type(op_type), .inv_op(inv_op),
    .inv_asid(inv_asid), .inv_vpn(inv_vpn), .flush(flush), .op_ready(op_ready),
    .data_req_valid(data_req_valid), .data_grant(data_grant), .tlbsrch_en(tlbsrch_en),
    .s1_found(s1_found), .s1_index(s1_index), .tlbrd_en(tlbrd_en), .tlbwr_en(tlbwr_en),
    .tlbfill_en(tlbfill_en), .rand_index(rand_index), .inv_en(inv_en), .inv_index(inv_index),
    .inv_op_o(inv_op_o), .inv_asid_o(inv_asid_o), .inv_vpn_o(inv_vpn_o), .done(done),
    .srch_found(srch_found), .srch_index(srch_index), .inv_illegal(inv_illegal), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the most recent accepted op and its accept cycle; every output follows from
  // the offset of the current cycle relative to that accept.
  int cyc, acc_cyc, m_type, m_lat, m_rand, m_sidx, m_iop, m_asid, m_vpn;
  bit have_op, m_ill, m_found;

  logic             s_done, s_inv_en, s_ready, s_found, s_ill, s_busy;
  logic [IDX_W-1:0] s_rand, s_sidx, s_inv_idx;

  task automatic model_reset();
    have_op = 0; acc_cyc = -1000; m_type = 0; m_lat = 0; m_rand = 0;
    m_found = 0; m_sidx = 0; m_ill = 0; m_iop = 0; m_asid = 0; m_vpn = 0;
  endtask

  task automatic tick();
    int rel;
    bit act, e_ready, e_inv, acc, srch_res;
    #1;
    rel      = cyc - acc_cyc;
    act      = have_op && rel >= 1 && rel <= m_lat;
    e_ready  = !act && !flush;
    e_inv    = act && m_type == 4 && !m_ill && rel <= TLBNUM;
    srch_res = have_op && m_type == 0 && rel >= 3;
    chk("op_ready",    op_ready,    e_ready);
    chk("busy",        busy,        act);
    chk("done",        done,        act && rel == m_lat);
    chk("data_grant",  data_grant,  data_req_valid && (!act || rel == m_lat));
    chk("tlbsrch_en",  tlbsrch_en,  act && rel == 1 && m_type == 0);
    chk("tlbrd_en",    tlbrd_en,    act && rel == 1 && m_type == 1);
    chk("tlbwr_en",    tlbwr_en,    act && rel == 1 && m_type == 2);
    chk("tlbfill_en",  tlbfill_en,  act && rel == 1 && m_type == 3);
    chk("inv_en",      inv_en,      e_inv);
    chk("inv_index",   inv_index,   e_inv ? rel - 1 : 0);
    chk("rand_index",  rand_index,  m_rand);
    chk("srch_found",  srch_found,  srch_res && m_found);
    chk("srch_index",  srch_index,  srch_res ? m_sidx : 0);
    chk("inv_illegal", inv_illegal, have_op && m_ill && rel >= m_lat);
    chk("inv_op_o",    inv_op_o,    m_iop);
    chk("inv_asid_o",  inv_asid_o,  m_asid);
    chk("inv_vpn_o",   inv_vpn_o,   m_vpn);
    s_done = done; s_inv_en = inv_en; s_inv_idx = inv_index; s_ready = op_ready;
    s_found = srch_found; s_sidx = srch_index; s_ill = inv_illegal; s_busy = busy;
    s_rand = rand_index;
    if (act && m_type == 0 && rel == 2) begin
      m_found = s1_found;
      m_sidx  = int'(s1_index);
    end
    acc = op_valid && e_ready;
    if (!act && !acc) m_rand = (m_rand + 1) % TLBNUM;
    if (acc) begin
      have_op = 1; acc_cyc = cyc; m_type = int'(op_type);
      m_ill   = (op_type == 3'd4) && (inv_op > 5'd6);
      m_lat   = (op_type <= 3'd1) ? 3 : (op_type == 3'd4 && !m_ill) ? TLBNUM + 1 : 2;
      m_iop   = int'(inv_op); m_asid = int'(inv_asid); m_vpn = int'(inv_vpn);
      m_found = 0; m_sidx = 0;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_inv_en"}, inv_en, 0);
    chk({tag, "_inv_index"}, inv_index, 0);
    chk({tag, "_rand"}, rand_index, 0);
    chk({tag, "_strobes"}, {tlbsrch_en, tlbrd_en, tlbwr_en, tlbfill_en}, 0);
    chk({tag, "_srch"}, {srch_found, srch_index, inv_illegal}, 0);
    chk({tag, "_operands"}, (inv_op_o != 0) || (inv_asid_o != 0) || (inv_vpn_o != 0), 0);
  endtask

  typedef struct {
    logic [2:0]       typ;
    logic [4:0]       iop;
    logic             s1f;
    logic [IDX_W-1:0] s1i;
    int               exp_lat;
    logic             exp_found;
    logic [IDX_W-1:0] exp_idx;
    logic             exp_ill;
    int               exp_inv_cnt;
  } vec_t;

  task automatic run_op(input logic [2:0] typ, input logic [4:0] iop, input logic f,
                        input logic [IDX_W-1:0] si, input logic hold_flush,
                        output int lat, output int inv_cnt, output bit seen);
    op_valid = 1; op_type = typ; inv_op = iop;
    inv_asid = 10'($urandom); inv_vpn = 19'($urandom);
    s1_found = f; s1_index = si; flush = 0;
    tick();
    op_valid = hold_flush; flush = hold_flush;
    lat = 0; inv_cnt = 0; seen = 0;
    for (int k = 1; k <= 100 && !seen; k++) begin
      tick();
      if (s_inv_en) inv_cnt++;
      if (s_done) begin seen = 1; lat = k; end
    end
    op_valid = 0; flush = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int lat, cnt, r1, r2, guard;
    bit seen;
    vecs[0] = '{3'd0, 5'd0,  1'b1, 5'd5,  3,          1'b1, 5'd5,  1'b0, 0};
    vecs[1] = '{3'd0, 5'd0,  1'b0, 5'd17, 3,          1'b0, 5'd17, 1'b0, 0};
    vecs[2] = '{3'd1, 5'd0,  1'b1, 5'd9,  3,          1'b0, 5'd0,  1'b0, 0};
    vecs[3] = '{3'd2, 5'd0,  1'b1, 5'd3,  2,          1'b0, 5'd0,  1'b0, 0};
    vecs[4] = '{3'd3, 5'd0,  1'b0, 5'd0,  2,          1'b0, 5'd0,  1'b0, 0};
    vecs[5] = '{3'd4, 5'd2,  1'b1, 5'd1,  TLBNUM + 1, 1'b0, 5'd0,  1'b0, TLBNUM};
    vecs[6] = '{3'd4, 5'd7,  1'b0, 5'd0,  2,          1'b0, 5'd0,  1'b1, 0};
    vecs[7] = '{3'd4, 5'd6,  1'b0, 5'd0,  TLBNUM + 1, 1'b0, 5'd0,  1'b0, TLBNUM};
    vecs[8] = '{3'd4, 5'd31, 1'b1, 5'd2,  2,          1'b0, 5'd0,  1'b1, 0};

    rst = 1; op_valid = 0; op_type = 0; inv_op = 0; inv_asid = 0; inv_vpn = 0;
    flush = 0; data_req_valid = 0; s1_found = 0; s1_index = 0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 0; cyc = 0; model_reset();
    repeat (3) tick();

    data_req_valid = 1;
    foreach (vecs[i]) begin
      run_op(vecs[i].typ, vecs[i].iop, vecs[i].s1f, vecs[i].s1i, 1'b0, lat, cnt, seen);
      chk($sformatf("vec%0d_done_seen", i), seen, 1);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_srch_found", i), s_found, vecs[i].exp_found);
      chk($sformatf("vec%0d_srch_index", i), s_sidx, vecs[i].exp_idx);
      chk($sformatf("vec%0d_inv_illegal", i), s_ill, vecs[i].exp_ill);
      chk($sformatf("vec%0d_inv_count", i), cnt, vecs[i].exp_inv_cnt);
    end

    // flush with op_valid in IDLE must not accept
    op_valid = 1; op_type = 3'd2; flush = 1;
    tick();
    chk("flush_idle_ready", s_ready, 0);
    op_valid = 0; flush = 0;
    tick();
    chk("flush_idle_busy", s_busy, 0);

    // back-to-back FILLs ten cycles apart
    op_valid = 1; op_type = 3'd3;
    tick();
    r1 = int'(s_rand); op_valid = 0;
    tick(); chk("fill_frozen_issue", s_rand, r1);
    tick(); chk("fill_frozen_done", s_rand, r1);
    repeat (7) tick();
    op_valid = 1;
    tick();
    r2 = int'(s_rand); op_valid = 0;
    chk("fill_index_differs", r1 != r2, 1);
    repeat (2) tick();

    // rand_index wrap
    guard = 0;
    tick();
    while (s_rand != 5'd31 && guard < 40) begin tick(); guard++; end
    chk("rand_reached_max", s_rand, 31);
    tick();
    chk("rand_wrap", s_rand, 0);

    // flush held during an INV walk does not cut it short
    run_op(3'd4, 5'd2, 1'b0, 5'd0, 1'b1, lat, cnt, seen);
    chk("flush_walk_done", seen, 1);
    chk("flush_walk_latency", lat, TLBNUM + 1);
    chk("flush_walk_count", cnt, TLBNUM);
    tick();

    // reset in the middle of an INV walk
    op_valid = 1; op_type = 3'd4; inv_op = 5'd3;
    tick();
    op_valid = 0; guard = 0;
    tick();
    while (!(s_inv_en && s_inv_idx == 5'd10) && guard < 50) begin tick(); guard++; end
    chk("rst_walk_reached_10", s_inv_idx, 10);
    rst = 1;
    #1;
    chk_reset_outputs("midrst");
    model_reset();
    @(negedge clk);
    rst = 0;
    repeat (3) tick();
    run_op(3'd2, 5'd0, 1'b0, 5'd0, 1'b0, lat, cnt, seen);
    chk("post_rst_wr_done", seen, 1);
    chk("post_rst_wr_latency", lat, 2);

    // random traffic against the model
    for (int i = 0; i < 700; i++) begin
      op_valid       = ($urandom_range(0, 3) == 0);
      op_type        = 3'($urandom_range(0, 4));
      inv_op         = 5'($urandom_range(0, 8));
      inv_asid       = 10'($urandom);
      inv_vpn        = 19'($urandom);
      flush          = ($urandom_range(0, 7) == 0);
      data_req_valid = 1'($urandom_range(0, 1));
      s1_found       = 1'($urandom_range(0, 1));
      s1_index       = 5'($urandom);
      tick();
    end
    op_valid = 0; flush = 0;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
